common_incr_counter: RTL and testbench

- Parametrised, registered up-counter, next generation of the 4-bit RTL-ROM incrementer.
- Width is generalised to any multiple of 4. The next value comes from a chain of 4-bit increment slices; each slice increments only when every lower slice is 4'hF.
- Adds load, clear, wrap/saturate mode, terminal-count and overflow reporting.
- Used as the shared counter primitive in timers, retry counters and perf-counter shadows.

---
 rtl/common_incr_counter.sv | 95 +++++++++
 tb/tb_common_incr_counter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/common_incr_counter.sv
// Registered up-counter built from chained 4-bit increment slices, with load/clear/saturate.
// Optional down-count (dir port, zc flag) when COMMON_INCR_COUNTER_DECR_EN is defined.

module common_incr_counter_slice (
    input  logic [3:0] d,
    input  logic       ci,
    input  logic       dn,
    output logic [3:0] nx,
    output logic       co
);
    // Up: carry out when all-ones; down: borrow out when all-zeros.
    always_comb begin
        nx = d;
        co = 1'b0;
        if (dn) begin
            co = ci & (d == 4'h0);
            if (ci) nx = d - 4'd1;
        end else begin
            co = ci & (d == 4'hF);
            if (ci) nx = d + 4'd1;
        end
    end
endmodule

module common_incr_counter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned RESET_VALUE = 0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_value,
    input  logic             en,
`ifdef COMMON_INCR_COUNTER_DECR_EN
    input  logic             dir,
    output logic             zc,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             ovf_sticky
);
    localparam int unsigned      NSL   = WIDTH / 4;
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("common_incr_counter: WIDTH must be a multiple of 4 and >= 4");
    end

    logic                  dn;
    logic [NSL:0]          cy;
    logic [NSL-1:0][3:0]   nx;
    logic [WIDTH-1:0]      q_nx;

`ifdef COMMON_INCR_COUNTER_DECR_EN
    assign dn = dir;
    assign zc = (q == '0);
`else
    assign dn = 1'b0;
`endif

    assign cy[0] = en;
    assign q_nx  = nx;
    assign tc    = &q;

    for (genvar k = 0; k < NSL; k++) begin : g_slice
        common_incr_counter_slice u_slice (
            .d  (q[4*k +: 4]),
            .ci (cy[k]),
            .dn (dn),
            .nx (nx[k]),
            .co (cy[k+1])
        );
    end

    // Final carry/borrow out is the overflow (or underflow) event.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q          <= RST_Q;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (ld) begin
            q   <= ld_value;
            ovf <= 1'b0;
        end else if (en) begin
            ovf <= cy[NSL];
            if (cy[NSL]) ovf_sticky <= 1'b1;
            if (!(SATURATE && cy[NSL])) q <= q_nx;
        end else begin
            ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_common_incr_counter.sv
// Directed bench: three counter configurations (8-bit wrap, 8-bit saturate with RESET_VALUE 5, 12-bit wrap).
module tb_common_incr_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr0 = 0, ld0 = 0, en0 = 0, clr1 = 0, ld1 = 0, en1 = 0, clr2 = 0, ld2 = 0, en2 = 0;
    logic [7:0]  ldv0 = '0, ldv1 = '0, q0, q1;
    logic [11:0] ldv2 = '0, q2;
    logic        tc0, tc1, tc2, ovf0, ovf1, ovf2, st0, st1, st2;
    int          n_chk = 0, n_fail = 0;
`ifdef COMMON_INCR_COUNTER_DECR_EN
    logic        dir0 = 0, dir1 = 0, dir2 = 0, zc0, zc1, zc2;
`endif

    always #5 clk = ~clk;

    common_incr_counter #(.WIDTH(8), .RESET_VALUE(0), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset(reset), .clr(clr0), .ld(ld0), .ld_value(ldv0), .en(en0),
`ifdef COMMON_INCR_COUNTER_DECR_EN
        .dir(dir0), .zc(zc0),
`endif
        .q(q0), .tc(tc0), .ovf(ovf0), .ovf_sticky(st0));

    common_incr_counter #(.WIDTH(8), .RESET_VALUE(5), .SATURATE(1'b1)) u1 (
        .clk(clk), .reset(reset), .clr(clr1), .ld(ld1), .ld_value(ldv1), .en(en1),
`ifdef COMMON_INCR_COUNTER_DECR_EN
        .dir(dir1), .zc(zc1),
`endif
        .q(q1), .tc(tc1), .ovf(ovf1), .ovf_sticky(st1));

    common_incr_counter #(.WIDTH(12), .RESET_VALUE(0), .SATURATE(1'b0)) u2 (
        .clk(clk), .reset(reset), .clr(clr2), .ld(ld2), .ld_value(ldv2), .en(en2),
`ifdef COMMON_INCR_COUNTER_DECR_EN
        .dir(dir2), .zc(zc2),
`endif
        .q(q2), .tc(tc2), .ovf(ovf2), .ovf_sticky(st2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        reset = 1'b0;
        chk("rst_q0", 16'(q0), 16'h00);  chk("rst_ovf0", 16'(ovf0), 0);
        chk("rst_st0", 16'(st0), 0);     chk("rst_tc0", 16'(tc0), 0);
        chk("rst_q1", 16'(q1), 16'h05);  chk("rst_q2", 16'(q2), 16'h000);

        // 8-bit wrap: full revolution
        en0 = 1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("cnt_q", 16'(q0), 16'(i % 256));
            chk("cnt_tc", 16'(tc0), 16'(i == 255));
            chk("cnt_ovf", 16'(ovf0), 16'(i == 256));
            chk("cnt_st", 16'(st0), 16'(i == 256));
        end
        en0 = 0;
        step();
        chk("cnt_ovf_drop", 16'(ovf0), 0); chk("cnt_st_hold", 16'(st0), 1);

        // load all-ones, then ld+en at all-ones, then clr masking an overflow
        ld0 = 1; ldv0 = 8'hFF; step();
        chk("ldff_q", 16'(q0), 16'hFF); chk("ldff_tc", 16'(tc0), 1); chk("ldff_ovf", 16'(ovf0), 0);
        ldv0 = 8'h12; en0 = 1; step();
        chk("ldpri_q", 16'(q0), 16'h12); chk("ldpri_ovf", 16'(ovf0), 0);
        ldv0 = 8'hFF; en0 = 0; step();
        ld0 = 0; clr0 = 1; en0 = 1; step();
        chk("clr_q", 16'(q0), 16'h00); chk("clr_ovf", 16'(ovf0), 0); chk("clr_st", 16'(st0), 0);
        clr0 = 0; en0 = 0;

        // 8-bit saturate
        ld1 = 1; ldv1 = 8'hFE; step();
        chk("sat_ld", 16'(q1), 16'hFE);
        ld1 = 0; en1 = 1; step();
        chk("sat_q1", 16'(q1), 16'hFF); chk("sat_ovf1", 16'(ovf1), 0);
        step();
        chk("sat_q2", 16'(q1), 16'hFF); chk("sat_ovf2", 16'(ovf1), 1);
        step();
        chk("sat_q3", 16'(q1), 16'hFF); chk("sat_ovf3", 16'(ovf1), 1); chk("sat_st", 16'(st1), 1);
        ld1 = 1; ldv1 = 8'h12; step();
        chk("satpri_q", 16'(q1), 16'h12); chk("satpri_ovf", 16'(ovf1), 0); chk("satpri_st", 16'(st1), 1);
        ld1 = 0; clr1 = 1; step();
        chk("satclr_q", 16'(q1), 16'h05); chk("satclr_st", 16'(st1), 0);
        clr1 = 0; en1 = 0;

        // 12-bit carry across slices
        ld2 = 1; ldv2 = 12'h0FF; step();
        ld2 = 0; en2 = 1; step();
        chk("w12_100", 16'(q2), 16'h100);
        ld2 = 1; en2 = 0; ldv2 = 12'h7FF; step();
        ld2 = 0; en2 = 1; step();
        chk("w12_800", 16'(q2), 16'h800); chk("w12_tc", 16'(tc2), 0);
        ld2 = 1; en2 = 0; ldv2 = 12'hFFF; step();
        chk("w12_tc_ff", 16'(tc2), 1);
        ld2 = 0; en2 = 1; step();
        chk("w12_wrap", 16'(q2), 16'h000); chk("w12_ovf", 16'(ovf2), 1);
        en2 = 0;

`ifdef COMMON_INCR_COUNTER_DECR_EN
        ld0 = 1; ldv0 = 8'h00; step();
        chk("dn_zc0", 16'(zc0), 1);
        ld0 = 0; dir0 = 1; en0 = 1; step();
        chk("dn_q1", 16'(q0), 16'hFF); chk("dn_ovf1", 16'(ovf0), 1); chk("dn_zc1", 16'(zc0), 0);
        step();
        chk("dn_q2", 16'(q0), 16'hFE); chk("dn_ovf2", 16'(ovf0), 0);
        en0 = 0; dir0 = 0;
        ld1 = 1; ldv1 = 8'h00; step();
        ld1 = 0; dir1 = 1; en1 = 1; step();
        chk("dnsat_q", 16'(q1), 16'h00); chk("dnsat_ovf", 16'(ovf1), 1);
        en1 = 0; dir1 = 0;
`endif

        // reset mid-count with RESET_VALUE 5
        ld1 = 1; ldv1 = 8'hFF; en1 = 1; step();
        ld1 = 0; step();
        chk("pre_st", 16'(st1), 1);
        ld1 = 1; ldv1 = 8'h10; en1 = 0; step();
        ld1 = 0; en1 = 1;
        for (int i = 0; i < 16; i++) step();
        chk("mid_q", 16'(q1), 16'h20);
        reset = 1; ld1 = 1; ldv1 = 8'h77; step();
        reset = 0; ld1 = 0; en1 = 0;
        chk("mid_rst_q", 16'(q1), 16'h05); chk("mid_rst_ovf", 16'(ovf1), 0);
        chk("mid_rst_st", 16'(st1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
